// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
// Requester IDs and owner FSM state encoding.
package ram_arbiter_pkg;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } own_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant from req[1:0], prio selects the winner on a tie.
// Purely combinational.
module ram_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | ~prio);
  assign gnt[1] = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port synchronous RAM between the core (m0) and the loader (m1).
// Combinational grants, round-robin with burst lock; read data returns one cycle after grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic                  i_m0_lock,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_gnt,
  output logic                  o_m0_rvalid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic                  i_m1_lock,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_rvalid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  own_state_t state, state_nxt;
  logic       prio, prio_nxt;
  logic       rd_pend, rd_who;
  logic [1:0] req, pick, gnt;

  assign req = {i_m1_req, i_m0_req};

  ram_arbiter_rr_pick2 u_pick (
    .req  (req),
    .prio (prio),
    .gnt  (pick)
  );

  // A locked owner drops back to FREE in the same cycle its access completes.
  always_comb begin
    gnt       = 2'b00;
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      FREE: begin
        gnt = pick;
        if (pick[0]) begin
          prio_nxt = REQ_LOADER;
          if (i_m0_lock) state_nxt = LOCK0;
        end else if (pick[1]) begin
          prio_nxt = REQ_CORE;
          if (i_m1_lock) state_nxt = LOCK1;
        end
      end
      LOCK0: begin
        gnt[0] = i_m0_req;
        if (!i_m0_req || !i_m0_lock) state_nxt = FREE;
      end
      LOCK1: begin
        gnt[1] = i_m1_req;
        if (!i_m1_req || !i_m1_lock) state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  always_comb begin
    o_ram_load = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (gnt[0]) begin
      o_ram_load = i_m0_we;
      o_ram_addr = i_m0_addr;
      o_ram_data = i_m0_wdata;
    end else if (gnt[1]) begin
      o_ram_load = i_m1_we;
      o_ram_addr = i_m1_addr;
      o_ram_data = i_m1_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= FREE;
      prio    <= REQ_CORE;
      rd_pend <= 1'b0;
      rd_who  <= REQ_CORE;
    end else begin
      state   <= state_nxt;
      prio    <= prio_nxt;
      rd_pend <= (gnt[0] & ~i_m0_we) | (gnt[1] & ~i_m1_we);
      rd_who  <= gnt[1];
    end
  end

  assign o_m0_gnt    = gnt[0];
  assign o_m1_gnt    = gnt[1];
  assign o_m0_rvalid = rd_pend & (rd_who == REQ_CORE);
  assign o_m1_rvalid = rd_pend & (rd_who == REQ_LOADER);
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_data : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter against a cycle-level reference model and a RAM model.
module tb_ram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [15:0] o_m0_rdata, o_m1_rdata;
  logic        o_ram_load;
  logic [7:0]  o_ram_addr;
  logic [15:0] o_ram_data;
  logic [15:0] ram_q;
  logic        ram_init;
  logic [15:0] mem [256];

  int tests = 0;
  int fails = 0;

  // reference model state
  int          owner;   // -1 free, else owning requester
  int          prio;
  bit          pend;
  int          who;
  logic [15:0] pdata;
  logic [15:0] ref_mem [256];

  always #5 i_clk = ~i_clk;

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock),
    .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock),
    .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_ram_load(o_ram_load), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .i_ram_data(ram_q)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16'h10) return 16'h1234;
    return 16'h4000 ^ (16'(i) * 16'h0101);
  endfunction

  // synchronous single-port RAM, one-cycle read latency
  always @(posedge i_clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (o_ram_load) begin
      mem[o_ram_addr] <= o_ram_data;
    end
    ram_q <= mem[o_ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    prio  = 0;
    pend  = 1'b0;
    who   = 0;
    pdata = '0;
  endtask

  task automatic step(input logic r0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                      input logic r1, w1, l1, input logic [7:0] a1, input logic [15:0] d1);
    bit g0, g1;
    logic [7:0]  ea;
    logic [15:0] ed;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    if (owner == 0)      begin g0 = r0; g1 = 1'b0; end
    else if (owner == 1) begin g0 = 1'b0; g1 = r1; end
    else if (r0 && r1)   begin g0 = (prio == 0); g1 = (prio == 1); end
    else                 begin g0 = r0; g1 = r1; end
    ea = g0 ? a0 : (g1 ? a1 : 8'h00);
    ed = g0 ? d0 : (g1 ? d1 : 16'h0000);
    @(negedge i_clk);
    chk("m0_gnt",    32'(o_m0_gnt),    32'(g0));
    chk("m1_gnt",    32'(o_m1_gnt),    32'(g1));
    chk("ram_load",  32'(o_ram_load),  32'((g0 && w0) || (g1 && w1)));
    chk("ram_addr",  32'(o_ram_addr),  32'(ea));
    chk("ram_data",  32'(o_ram_data),  32'(ed));
    chk("m0_rvalid", 32'(o_m0_rvalid), 32'(pend && who == 0));
    chk("m1_rvalid", 32'(o_m1_rvalid), 32'(pend && who == 1));
    chk("m0_rdata",  32'(o_m0_rdata),  (pend && who == 0) ? 32'(pdata) : 32'h0);
    chk("m1_rdata",  32'(o_m1_rdata),  (pend && who == 1) ? 32'(pdata) : 32'h0);
    @(posedge i_clk);
    pend = 1'b0;
    if (g0 || g1) begin
      if ((g0 && !w0) || (g1 && !w1)) begin
        pend  = 1'b1;
        who   = g1 ? 1 : 0;
        pdata = ref_mem[ea];
      end else begin
        ref_mem[ea] = ed;
      end
    end
    if (owner == -1) begin
      if (g0) begin prio = 1; if (l0) owner = 0; end
      else if (g1) begin prio = 0; if (l1) owner = 1; end
    end else if (owner == 0) begin
      if (!r0 || !l0) owner = -1;
    end else begin
      if (!r1 || !l1) owner = -1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    i_rst_n = 1'b0; ram_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge i_clk);
    #1 ram_init = 1'b0;
    @(negedge i_clk);
    chk("rst_m0_rvalid", 32'(o_m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(o_m1_rvalid), 32'h0);
    chk("rst_ram_load",  32'(o_ram_load),  32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // contention from reset: m0, m1, m0, m1
    for (int k = 0; k < 4; k++) step(1, 0, 0, 8'(k), 16'h0, 1, 0, 0, 8'(8 + k), 16'h0);
    // single read of 0x10
    step(1, 0, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    idle();
    chk("single_rd_data", 32'(pdata), 32'h1234);
    // make m1 favoured, then m1 locked write burst while m0 keeps requesting
    step(1, 0, 0, 8'h01, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    step(1, 0, 0, 8'h02, 16'h0, 1, 1, 1, 8'h20, 16'hAAAA);
    step(1, 0, 0, 8'h02, 16'h0, 1, 1, 1, 8'h21, 16'hBBBB);
    step(1, 0, 0, 8'h02, 16'h0, 1, 1, 0, 8'h22, 16'hCCCC);
    step(1, 0, 0, 8'h02, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'(8'h20 + k), 16'h0);
    idle();
    chk("lock_rb_2", 32'(ref_mem[8'h22]), 32'hCCCC);
    // write then read same address
    step(1, 1, 0, 8'h05, 16'h5A5A, 0, 0, 0, 8'h00, 16'h0);
    step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0);
    step(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    idle();
    // reset mid-read with prio pointing at m1
    step(1, 0, 0, 8'h03, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    idle();
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    @(negedge i_clk);
    chk("pre_rst_gnt", 32'(o_m0_gnt), 32'h1);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    m0_req = 0;
    chk("in_rst_m0_rvalid", 32'(o_m0_rvalid), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    @(posedge i_clk); #1;
    step(1, 0, 0, 8'h07, 16'h0, 1, 0, 0, 8'h08, 16'h0);
    step(1, 0, 0, 8'h07, 16'h0, 1, 0, 0, 8'h08, 16'h0);
    idle();
    idle();

    // randomized traffic, addresses kept small to force collisions
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), 16'($urandom));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
